// File: rtl/bsram_ctrl.sv
// ----------------------------------------------------------------------------
// bsram_ctrl
//
// Sequencer and arbiter for the single-port instruction BSRAM (Gowin_SP).
// After reset it copies a fixed boot image from a combinational ROM table into
// the BSRAM, one word per cycle, while holding the CPU. Once the copy is done
// it shares the single memory port between CPU instruction fetch and an
// optional external program-loader write port.
//
// Optional feature macro: BSRAM_CTRL_LOADER_EN
//   defined   : loader write port with burst-limited priority over the CPU.
//   undefined : loader inputs ignored, ld_ready tied 0, CPU owns the port
//               every RUN cycle.
//
// Ports:
//   clk, rst          system clock; asynchronous active-low reset
//   boot_rom_addr/
//   boot_rom_data     boot ROM index and combinational word at that index
//   cpu_addr          CPU fetch address (held by the CPU while cpu_stall=1)
//   cpu_stall         CPU read not granted this cycle
//   cpu_rdata         fetched word (mem_dout passed through)
//   cpu_rvalid        cpu_rdata valid (cycle after a CPU grant)
//   cpu_hold          holds the CPU in reset until boot completes
//   ld_valid/ld_ready/
//   ld_addr/ld_data   loader write request channel
//   mem_ce/mem_wre/
//   mem_ad/mem_din    BSRAM control, address and write data
//   mem_dout          BSRAM read data, 1-cycle latency, write-first
//   boot_done         boot copy finished
//   dbg_state         0 = RESET, 1 = BOOT, 2 = RUN
// ----------------------------------------------------------------------------
module bsram_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int BOOT_LEN  = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] boot_rom_addr,
  input  logic [DATA_W-1:0] boot_rom_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_hold,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              boot_done,
  output logic [1:0]        dbg_state
);

  // RESET is not a stored state: it is simply rst low. The register resets
  // straight into BOOT so the first boot write lands on the first clock edge
  // after rst is released.
  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] BOOT_LAST = ADDR_W'(BOOT_LEN - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   bc_q, bc_d;
  logic                cpu_rvalid_q;
  logic                boot_done_q;
  logic                cpu_grant;

  // Loader handshake: a write is transferred in the cycle where ld_valid and
  // ld_ready are both high at the clock edge. ld_ready is only ever raised in
  // response to ld_valid, and the loader keeps ld_addr/ld_data stable while
  // ld_valid is high and ld_ready is low.
`ifdef BSRAM_CTRL_LOADER_EN
  localparam int              BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          ld_grant;

  // After MAX_BURST back-to-back loader grants the CPU gets one cycle.
  assign ld_grant = ld_valid && (burst_cnt_q < BURST_MAX);
`else
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_addr, ld_data};
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc_q         <= '0;
      cpu_rvalid_q <= 1'b0;
      boot_done_q  <= 1'b0;
    end else begin
      bc_q         <= bc_d;
      cpu_rvalid_q <= cpu_grant;
      boot_done_q  <= (state_d == S_RUN);
    end
  end

`ifdef BSRAM_CTRL_LOADER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Next state and memory-port control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    cpu_grant = 1'b0;
    mem_ce    = 1'b0;
    mem_wre   = 1'b0;
    mem_ad    = '0;
    mem_din   = '0;
    ld_ready  = 1'b0;
    cpu_stall = 1'b1;
`ifdef BSRAM_CTRL_LOADER_EN
    burst_cnt_d = burst_cnt_q;
`endif

    // While rst is low every combinational output sits at its reset value,
    // which also keeps an in-flight loader write from being accepted.
    if (rst) begin
      unique case (state_q)
        S_BOOT: begin
          mem_ce  = 1'b1;
          mem_wre = 1'b1;
          mem_ad  = bc_q;
          mem_din = boot_rom_data;
          // bc stops at the last word rather than wrapping.
          if (bc_q == BOOT_LAST) begin
            state_d = S_RUN;
          end else begin
            bc_d = bc_q + ADDR_W'(1);
          end
        end

        S_RUN: begin
          mem_ce = 1'b1;
`ifdef BSRAM_CTRL_LOADER_EN
          if (ld_grant) begin
            ld_ready    = 1'b1;
            mem_wre     = 1'b1;
            mem_ad      = ld_addr;
            mem_din     = ld_data;
            burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q
                                                     : burst_cnt_q + BW'(1);
          end else begin
            cpu_grant   = 1'b1;
            cpu_stall   = 1'b0;
            mem_ad      = cpu_addr;
            burst_cnt_d = '0;
          end
`else
          cpu_grant = 1'b1;
          cpu_stall = 1'b0;
          mem_ad    = cpu_addr;
`endif
        end

        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign boot_rom_addr = bc_q;
  assign boot_done     = boot_done_q;
  assign cpu_hold      = ~boot_done_q;
  assign cpu_rvalid    = cpu_rvalid_q;
  // Write-first BSRAM already returns fresh data for a read that follows a
  // write to the same address, so read data needs no bypass.
  assign cpu_rdata     = mem_dout;

  always_comb begin
    dbg_state = 2'd0;
    if (rst) begin
      dbg_state = (state_q == S_BOOT) ? 2'd1 : 2'd2;
    end
  end

endmodule

// File: doc/bsram_ctrl.md
# bsram_ctrl

Sequencer and arbiter for the single-port instruction BSRAM (Gowin_SP, 2K×16). After reset it copies a fixed boot image from a combinational ROM table into BSRAM while holding the CPU. It then shares the one memory port between CPU instruction fetch (read) and an external program-loader write port, with loader priority and a starvation guard. It sits between the top level, the BSRAM macro and the `cpu` instance, replacing ad-hoc boot/address muxing.

## Interface
- `ADDR_W`, default 11: BSRAM address width.
- `DATA_W`, default 16: BSRAM data width.
- `BOOT_LEN`, default 16: boot image words copied to addresses 0..BOOT_LEN-1. Legal range 1..2^ADDR_W.
- `MAX_BURST`, default 4: maximum number of consecutive loader grants before one CPU cycle is forced. Must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `boot_rom_addr`  out  ADDR_W  index into the boot ROM table.
- `boot_rom_data`  in  DATA_W  boot word at `boot_rom_addr`, combinational.
- `cpu_addr`  in  ADDR_W  CPU fetch address.
- `cpu_stall`  out  1  high when the CPU read is not granted this cycle.
- `cpu_rdata`  out  DATA_W  fetched word.
- `cpu_rvalid`  out  1  `cpu_rdata` is valid.
- `cpu_hold`  out  1  holds the CPU in reset until boot completes.
- `ld_valid`  in  1  loader write request.
- `ld_ready`  out  1  loader write accepted this cycle.
- `ld_addr`  in  ADDR_W  loader write address.
- `ld_data`  in  DATA_W  loader write data.
- `mem_ce`  out  1  BSRAM chip enable.
- `mem_wre`  out  1  BSRAM write enable.
- `mem_ad`  out  ADDR_W  BSRAM address.
- `mem_din`  out  DATA_W  BSRAM write data.
- `mem_dout`  in  DATA_W  BSRAM read data, 1-cycle latency.
- `boot_done`  out  1  boot copy finished.

## Operation
- States:
  - RESET: while `rst` is low.
  - BOOT: sequential boot copy.
  - RUN: normal arbitration.
- BOOT:
  - Boot counter `bc` runs 0..BOOT_LEN-1, one write per cycle.
  - `boot_rom_addr = bc`. Memory drives `mem_ce=1`, `mem_wre=1`, `mem_ad=bc`, `mem_din=boot_rom_data`.
  - After the write with `bc == BOOT_LEN-1`, go to RUN. `bc` does not wrap.
  - `ld_ready=0` and `cpu_stall=1` throughout BOOT.
- RUN arbitration, evaluated each cycle:
  - Loader is granted when `ld_valid=1` and `burst_cnt < MAX_BURST`.
  - On a loader grant: `ld_ready=1`, `mem_wre=1`, `mem_ad=ld_addr`, `mem_din=ld_data`, `cpu_stall=1`, and `burst_cnt` increments.
  - Otherwise the CPU is granted: `mem_wre=0`, `mem_ad=cpu_addr`, `cpu_stall=0`, and `burst_cnt` clears to 0.
  - `mem_ce=1` in every cycle of RUN.
- Read return:
  - `cpu_rvalid` is registered and is 1 in the cycle after a CPU grant.
  - `cpu_rdata = mem_dout`, passed through combinationally.
- Write-then-read hazard: a CPU read of an address written by the loader in the previous cycle returns the new data. BSRAM is in write-first mode; no extra logic is required.
- `burst_cnt` width: `clog2(MAX_BURST+1)`. It saturates and never wraps.
- Reset mid-operation: any `rst` low returns to RESET, then BOOT restarts from `bc=0`. An in-flight loader write is not accepted.

## Timing
- Reset values of all outputs:
  - `mem_ce=0`, `mem_wre=0`, `mem_ad=0`, `mem_din=0`.
  - `ld_ready=0`, `cpu_stall=1`, `cpu_rvalid=0`, `cpu_hold=1`, `boot_done=0`, `boot_rom_addr=0`.
- Boot timing:
  - First boot write happens on the first `clk` edge after `rst` deasserts.
  - Last boot write is at cycle BOOT_LEN-1.
  - `boot_done` rises and `cpu_hold` falls at cycle BOOT_LEN. Both are registered.
- Memory control outputs are combinational from state, registers and request inputs. The request inputs must be stable before the clock edge.
- Loader handshake:
  - A write completes in the cycle where `ld_valid && ld_ready` is sampled high.
  - The loader must hold `ld_addr` and `ld_data` while `ld_valid=1` and `ld_ready=0`.
  - `ld_ready` never asserts without `ld_valid`.
- CPU fetch latency: 1 cycle from grant to `cpu_rvalid`. The CPU must hold `cpu_addr` while `cpu_stall=1`.

## Configuration
- `BSRAM_CTRL_LOADER_EN`
  - Defined: loader port and burst arbitration are present, as described above.
  - Undefined: `ld_ready` is tied 0 and the loader inputs are ignored. `burst_cnt` is removed. In RUN the CPU is granted every cycle, so `cpu_stall=0` always in RUN.
  - BOOT behaviour is identical in both builds.

## Test plan
- Boot copy: with BOOT_LEN=16 and ROM word i = 16'hA000+i, release reset. Required: writes to addresses 0..15 in consecutive cycles, then `boot_done=1` and `cpu_hold=0` at cycle 16, and BSRAM[5] = 16'hA005.
- CPU fetch: in RUN, apply `cpu_addr`=3 with no loader request. Required: `cpu_stall=0`, and the next cycle gives `cpu_rvalid=1` with `cpu_rdata`=16'hA003.
- Loader priority: hold `ld_valid=1` continuously with MAX_BURST=4. Required: repeating pattern of 4 cycles with `ld_ready=1` and `cpu_stall=1`, then 1 CPU cycle with `ld_ready=0` and `cpu_stall=0`.
- Write then read: loader writes addr 7 = 16'h1234, then the CPU fetches addr 7 in the next cycle. Required: `cpu_rdata`=16'h1234.
- Reset mid-boot: drive `rst` low at boot cycle 8. Required: all outputs return to their reset values immediately, and after release the boot restarts at address 0 with 16 writes.
- Macro off: build without `BSRAM_CTRL_LOADER_EN` and drive `ld_valid=1`. Required: `ld_ready` stays 0, `cpu_stall=0` throughout RUN, and BSRAM contents are unchanged.
